mux8_valve_ctrl: RTL and testbench

Sequencer that drives the six pneumatic control lines of the 8-inlet fluidic multiplexer (three binary valve levels, paired lines c1/c2, c3/c4, c5/c6). It accepts a select-and-dwell request over a valid/ready handshake and closes every valve for a settle interval before opening the new path (break-before-make). It holds the path for the requested number of cycles, then closes everything and reports completion. It sits between the assay scheduler and the solenoid driver bank that pressurizes the mux control inlets.

---
 rtl/mux8_valve_if.sv | 26 ++
 rtl/mux8_valve_ctrl.sv | 134 +++++++++++++
 tb/tb_mux8_valve_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux8_valve_if.sv
// Request/valve bundle between the assay scheduler (master) and the
// 8-inlet mux valve sequencer (slave).
interface mux8_valve_if #(
   parameter int unsigned DWELL_W = 16
);
   logic               req_valid;
   logic               req_ready;
   logic [2:0]         req_sel;
   logic [DWELL_W-1:0] req_dwell;
   logic               abort;
   logic [5:0]         valve_close;
   logic               path_open;
   logic [2:0]         active_sel;
   logic               done;
   logic               aborted;

   modport master (
      output req_valid, req_sel, req_dwell, abort,
      input  req_ready, valve_close, path_open, active_sel, done, aborted
   );

   modport slave (
      input  req_valid, req_sel, req_dwell, abort,
      output req_ready, valve_close, path_open, active_sel, done, aborted
   );
endinterface

// File: rtl/mux8_valve_ctrl.sv
// Break-before-make sequencer for the six control lines of the 8-inlet
// fluidic mux: all-closed settle, timed open path, then done/aborted report.
module mux8_valve_ctrl #(
   parameter int unsigned SETTLE_CYC = 4,   // 1..255
   parameter int unsigned DWELL_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   mux8_valve_if.slave bus
);

   localparam int unsigned      SET_W     = 8;
   localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC);
   localparam logic [5:0]       ALL_CLOSED = 6'h3F;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_OPEN
   } state_e;

   state_e             state_q, state_d;
   logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [2:0]         sel_q, sel_d;
   logic [5:0]         valve_close_q, valve_close_d;
   logic               path_open_q, path_open_d;
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;
   logic               req_ready;
   logic               accept;

   // Each level opens exactly one line of its pair: c(2i+1) when the bit is 0.
   function automatic logic [5:0] path_pattern(input logic [2:0] sel);
      logic [5:0] p;
      for (int i = 0; i < 3; i++) begin
         p[2*i]   = sel[i];
         p[2*i+1] = ~sel[i];
      end
      return p;
   endfunction

   assign req_ready = (state_q == S_IDLE) && !rst;
   assign accept    = bus.req_valid && req_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      dwell_cnt_d  = dwell_cnt_q;
      sel_d        = sel_q;
      done_d       = 1'b0;
      aborted_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               sel_d        = bus.req_sel;
               dwell_cnt_d  = bus.req_dwell;
               settle_cnt_d = SETTLE_LD;
               state_d      = S_SETTLE;
            end
         end

         S_SETTLE: begin
            settle_cnt_d = settle_cnt_q - 1'b1;
            if (bus.abort) begin
               state_d   = S_IDLE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (settle_cnt_q == SET_W'(1)) begin
               if (dwell_cnt_q != '0) begin
                  state_d = S_OPEN;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         S_OPEN: begin
            // Entered only with a nonzero dwell and left at 1, so this never wraps.
            dwell_cnt_d = dwell_cnt_q - 1'b1;
            if (bus.abort) begin
               state_d   = S_IDLE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (dwell_cnt_q == DWELL_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Valve lines are decoded from the next state so they switch in one edge.
      path_open_d   = (state_d == S_OPEN);
      valve_close_d = path_open_d ? path_pattern(sel_d) : ALL_CLOSED;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q       <= S_IDLE;
         settle_cnt_q  <= '0;
         dwell_cnt_q   <= '0;
         sel_q         <= '0;
         valve_close_q <= ALL_CLOSED;
         path_open_q   <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         dwell_cnt_q   <= dwell_cnt_d;
         sel_q         <= sel_d;
         valve_close_q <= valve_close_d;
         path_open_q   <= path_open_d;
         done_q        <= done_d;
         aborted_q     <= aborted_d;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.valve_close = valve_close_q;
   assign bus.path_open   = path_open_q;
   assign bus.active_sel  = sel_q;
   assign bus.done        = done_q;
   assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_mux8_valve_ctrl.sv
// Directed bench for mux8_valve_ctrl: hand-computed expectations at each step
// plus a per-cycle monitor for the pair invariant and open-to-open spacing.
module tb_mux8_valve_ctrl;

   localparam int unsigned SETTLE_CYC = 4;
   localparam int unsigned DWELL_W    = 16;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mux8_valve_if #(.DWELL_W(DWELL_W)) bus ();

   mux8_valve_ctrl #(
      .SETTLE_CYC(SETTLE_CYC),
      .DWELL_W   (DWELL_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_out(input string tag, input logic [5:0] vc, input logic po,
                          input logic dn, input logic ab);
      chk({tag, ".valve_close"}, 32'(bus.valve_close), 32'(vc));
      chk({tag, ".path_open"},   32'(bus.path_open),   32'(po));
      chk({tag, ".done"},        32'(bus.done),        32'(dn));
      chk({tag, ".aborted"},     32'(bus.aborted),     32'(ab));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents a request for one edge; returns in cycle T+1 after the accept.
   task automatic send(input logic [2:0] sel, input logic [DWELL_W-1:0] dwell);
      bus.req_valid = 1'b1;
      bus.req_sel   = sel;
      bus.req_dwell = dwell;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Every cycle: no pair fully vented, and open periods spaced by >= SETTLE_CYC+1 closed cycles.
   int   closed_run;
   logic prev_open;
   logic seen_open;
   initial begin
      closed_run = 0;
      prev_open  = 1'b0;
      seen_open  = 1'b0;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("pair_not_both_open", 32'({bus.valve_close[2*i+1], bus.valve_close[2*i]} != 2'b00), 32'd1);
      end
      if (bus.path_open && !prev_open && seen_open) begin
         chk("open_gap", 32'(closed_run >= int'(SETTLE_CYC + 1)), 32'd1);
      end
      if (bus.path_open) begin
         closed_run = 0;
         seen_open  = 1'b1;
      end else begin
         closed_run++;
      end
      prev_open = bus.path_open;
   end

   logic [5:0] pat_tbl [8];

   initial begin
      n_cmp = 0;
      n_err = 0;
      pat_tbl = '{6'h2A, 6'h29, 6'h26, 6'h25, 6'h1A, 6'h19, 6'h16, 6'h15};

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_sel   = '0;
      bus.req_dwell = '0;
      bus.abort     = 1'b0;

      // Reset values
      cyc(3);
      exp_out("reset", 6'h3F, 1'b0, 1'b0, 1'b0);
      chk("reset.req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset.active_sel", 32'(bus.active_sel), 32'd0);
      rst = 1'b0;
      #1;
      chk("release.req_ready", 32'(bus.req_ready), 32'd1);

      // Idle for 10 cycles
      repeat (10) begin
         cyc(1);
         exp_out("idle", 6'h3F, 1'b0, 1'b0, 1'b0);
         chk("idle.req_ready", 32'(bus.req_ready), 32'd1);
      end

      // sel=5, dwell=3: settle T+1..T+4, open T+5..T+7, done T+8
      send(3'd5, 16'd3);
      chk("t2.active_sel", 32'(bus.active_sel), 32'd5);
      chk("t2.req_ready_busy", 32'(bus.req_ready), 32'd0);
      repeat (4) begin
         exp_out("t2_settle", 6'h3F, 1'b0, 1'b0, 1'b0);
         cyc(1);
      end
      repeat (3) begin
         exp_out("t2_open", 6'h19, 1'b1, 1'b0, 1'b0);
         cyc(1);
      end
      exp_out("t2_done", 6'h3F, 1'b0, 1'b1, 1'b0);
      chk("t2_done.req_ready", 32'(bus.req_ready), 32'd1);
      cyc(1);
      exp_out("t2_after", 6'h3F, 1'b0, 1'b0, 1'b0);

      // Sweep sel 0..7 with dwell=1, back to back on each done cycle
      for (int s = 0; s < 8; s++) begin
         send(3'(s), 16'd1);
         cyc(4);
         exp_out("t3_open", pat_tbl[s], 1'b1, 1'b0, 1'b0);
         chk("t3_open.active_sel", 32'(bus.active_sel), 32'(s));
         cyc(1);
         exp_out("t3_done", 6'h3F, 1'b0, 1'b1, 1'b0);
      end

      // sel=2, dwell=100, abort 10 cycles into OPEN, then accept on the done cycle
      send(3'd2, 16'd100);
      cyc(4);
      exp_out("t4_open_first", 6'h26, 1'b1, 1'b0, 1'b0);
      cyc(10);
      exp_out("t4_open_late", 6'h26, 1'b1, 1'b0, 1'b0);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      exp_out("t4_abort", 6'h3F, 1'b0, 1'b1, 1'b1);
      chk("t4_abort.req_ready", 32'(bus.req_ready), 32'd1);
      send(3'd3, 16'd1);
      chk("t4_next.active_sel", 32'(bus.active_sel), 32'd3);
      chk("t4_next.req_ready", 32'(bus.req_ready), 32'd0);
      cyc(4);
      exp_out("t4_next_open", 6'h25, 1'b1, 1'b0, 1'b0);
      cyc(1);
      exp_out("t4_next_done", 6'h3F, 1'b0, 1'b1, 1'b0);

      // Abort during SETTLE
      send(3'd4, 16'd5);
      cyc(1);
      exp_out("settle_abort_pre", 6'h3F, 1'b0, 1'b0, 1'b0);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      exp_out("settle_abort", 6'h3F, 1'b0, 1'b1, 1'b1);
      cyc(1);
      exp_out("settle_abort_after", 6'h3F, 1'b0, 1'b0, 1'b0);

      // Abort in the same cycle as dwell expiry: completes as aborted
      send(3'd1, 16'd1);
      cyc(4);
      exp_out("prio_open", 6'h29, 1'b1, 1'b0, 1'b0);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      exp_out("prio_abort", 6'h3F, 1'b0, 1'b1, 1'b1);

      // Abort in IDLE is ignored
      cyc(1);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      exp_out("idle_abort", 6'h3F, 1'b0, 1'b0, 1'b0);
      chk("idle_abort.req_ready", 32'(bus.req_ready), 32'd1);

      // dwell=0 with req_valid held; second request (sel=7, dwell=2) accepted at T+5
      bus.req_valid = 1'b1;
      bus.req_sel   = 3'd0;
      bus.req_dwell = 16'd0;
      cyc(1);
      bus.req_sel   = 3'd7;
      bus.req_dwell = 16'd2;
      chk("t5.active_sel", 32'(bus.active_sel), 32'd0);
      repeat (4) begin
         exp_out("t5_settle", 6'h3F, 1'b0, 1'b0, 1'b0);
         cyc(1);
      end
      exp_out("t5_done", 6'h3F, 1'b0, 1'b1, 1'b0);
      chk("t5_done.req_ready", 32'(bus.req_ready), 32'd1);
      chk("t5_done.active_sel", 32'(bus.active_sel), 32'd0);
      cyc(1);
      bus.req_valid = 1'b0;
      chk("t5_second.active_sel", 32'(bus.active_sel), 32'd7);
      chk("t5_second.req_ready", 32'(bus.req_ready), 32'd0);
      cyc(4);
      exp_out("t5_second_open0", 6'h15, 1'b1, 1'b0, 1'b0);
      cyc(1);
      exp_out("t5_second_open1", 6'h15, 1'b1, 1'b0, 1'b0);
      cyc(1);
      exp_out("t5_second_done", 6'h3F, 1'b0, 1'b1, 1'b0);

      // Reset mid-OPEN (sel=6): all closed, no done; then a normal request
      send(3'd6, 16'd20);
      cyc(6);
      exp_out("t6_open", 6'h16, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1);
      exp_out("t6_reset", 6'h3F, 1'b0, 1'b0, 1'b0);
      chk("t6_reset.req_ready", 32'(bus.req_ready), 32'd0);
      chk("t6_reset.active_sel", 32'(bus.active_sel), 32'd0);
      rst = 1'b0;
      cyc(1);
      exp_out("t6_idle", 6'h3F, 1'b0, 1'b0, 1'b0);
      chk("t6_idle.req_ready", 32'(bus.req_ready), 32'd1);
      send(3'd1, 16'd2);
      chk("t6_new.active_sel", 32'(bus.active_sel), 32'd1);
      cyc(4);
      exp_out("t6_new_open0", 6'h29, 1'b1, 1'b0, 1'b0);
      cyc(1);
      exp_out("t6_new_open1", 6'h29, 1'b1, 1'b0, 1'b0);
      cyc(1);
      exp_out("t6_new_done", 6'h3F, 1'b0, 1'b1, 1'b0);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
